// File: rtl/router_ctrl.sv
// Packet write sequencer for the 1x3 router, with per-port read-timeout soft resets.
// DECODE_ADDRESS wait header | WAIT_TILL_EMPTY hold for FIFO | LOAD_FIRST_DATA header write | LOAD_DATA payload
// FIFO_FULL stall | LOAD_AFTER_FULL held byte write | LOAD_PARITY parity write | CHECK_PARITY parity strobe
module router_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CW      = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] addr_in,
    input  logic [2:0] full,
    input  logic [2:0] empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       detect_add,
    output logic       chk_state,
    output logic       busy,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           addr_q, addr_d;
    logic                 par_pend_q, par_pend_d;
    logic [2:0][CW-1:0]   cnt_q, cnt_d;
    logic [2:0]           soft_reset_q, soft_reset_d;

    logic [3:0] full4, empty4, soft4, we4;
    logic       full_sel, abort, wr;

    // Padded to four entries so the 2-bit address never selects past the vector.
    assign full4    = {1'b0, full};
    assign empty4   = {1'b0, empty};
    assign soft4    = {1'b0, soft_reset_q};
    assign full_sel = full4[addr_q];
    assign abort    = soft4[addr_q] && (state_q != DECODE_ADDRESS);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        par_pend_d = par_pend_q;
        wr         = 1'b0;
        lfd_state  = 1'b0;
        ld_state   = 1'b0;
        laf_state  = 1'b0;
        detect_add = 1'b0;
        chk_state  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                if (pkt_valid && addr_in != 2'd3) begin
                    addr_d  = addr_in;
                    state_d = empty4[addr_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                busy = 1'b1;
                if (empty4[addr_q]) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
                wr        = 1'b1;
                state_d   = LOAD_DATA;
            end
            LOAD_DATA: begin
                ld_state = 1'b1;
                wr       = pkt_valid & ~full_sel;
                if (full_sel) begin
                    state_d    = FIFO_FULL;
                    par_pend_d = 1'b0;
                end else if (!pkt_valid) begin
                    state_d = LOAD_PARITY;
                end
            end
            FIFO_FULL: begin
                busy = 1'b1;
                if (!full_sel) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                laf_state = 1'b1;
                busy      = 1'b1;
                wr        = 1'b1;
                if (par_pend_q)     state_d = CHECK_PARITY;
                else if (pkt_valid) state_d = LOAD_DATA;
                else                state_d = LOAD_PARITY;
            end
            LOAD_PARITY: begin
                busy = 1'b1;
                wr   = ~full_sel;
                if (full_sel) begin
                    state_d    = FIFO_FULL;
                    par_pend_d = 1'b1;
                end else begin
                    state_d = CHECK_PARITY;
                end
            end
            CHECK_PARITY: begin
                busy      = 1'b1;
                chk_state = 1'b1;
                state_d   = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // The flushed FIFO must not receive any byte of the abandoned packet.
        if (abort) begin
            state_d = DECODE_ADDRESS;
            wr      = 1'b0;
        end
    end

    assign we4       = 4'(wr) << addr_q;
    assign write_enb = we4[2:0];
    assign vld_out   = ~empty;
    assign soft_reset = soft_reset_q;

    always_comb begin
        cnt_d        = cnt_q;
        soft_reset_d = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (read_enb[i] || empty[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(TIMEOUT - 1)) begin
                cnt_d[i]        = '0;
                soft_reset_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= DECODE_ADDRESS;
            addr_q       <= 2'd0;
            par_pend_q   <= 1'b0;
            cnt_q        <= '0;
            soft_reset_q <= 3'b000;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            par_pend_q   <= par_pend_d;
            cnt_q        <= cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

endmodule

// File: tb/tb_router_ctrl.sv
// Directed bench for router_ctrl: packet sequencing, full stalls, timeouts, abort and reset.
module tb_router_ctrl;

    logic       clock = 1'b0;
    logic       resetn, pkt_valid;
    logic [1:0] addr_in;
    logic [2:0] full, empty, read_enb;
    logic [2:0] write_enb, vld_out, soft_reset;
    logic       lfd_state, ld_state, laf_state, detect_add, chk_state, busy;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int lfd_cnt = 0;

    router_ctrl #(.TIMEOUT(30), .CW(5)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .addr_in(addr_in),
        .full(full), .empty(empty), .read_enb(read_enb), .write_enb(write_enb),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .detect_add(detect_add), .chk_state(chk_state), .busy(busy),
        .vld_out(vld_out), .soft_reset(soft_reset)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic settle;
        #1;
        if (write_enb != 3'b000) wr_cnt++;
        if (lfd_state) lfd_cnt++;
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; addr_in = 2'd0;
        full = 3'b000; empty = 3'b111; read_enb = 3'b000;
        tick; tick;
        resetn = 1'b1;
        settle;
        chk("rst_detect", 32'(detect_add), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we", 32'(write_enb), 0);
        chk("rst_soft", 32'(soft_reset), 0);
        chk("rst_vld", 32'(vld_out), 0);

        // address 3 is ignored
        pkt_valid = 1'b1; addr_in = 2'd3;
        tick; settle;
        chk("addr3_stay", 32'(detect_add), 1);
        chk("addr3_we", 32'(write_enb), 0);

        // clean packet, addr 1, four payload bytes
        wr_cnt = 0; lfd_cnt = 0;
        addr_in = 2'd1; settle;
        chk("cp_decode", 32'(detect_add), 1);
        tick; settle;
        chk("cp_lfd", 32'(lfd_state), 1);
        chk("cp_lfd_we", 32'(write_enb), 2);
        chk("cp_lfd_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            tick; settle;
            chk("cp_ld", 32'(ld_state), 1);
            chk("cp_ld_we", 32'(write_enb), 2);
            chk("cp_ld_busy", 32'(busy), 0);
        end
        tick; pkt_valid = 1'b0; settle;
        chk("cp_ld_end_we", 32'(write_enb), 0);
        tick; settle;
        chk("cp_lp_we", 32'(write_enb), 2);
        chk("cp_lp_busy", 32'(busy), 1);
        tick; settle;
        chk("cp_chk", 32'(chk_state), 1);
        chk("cp_chk_we", 32'(write_enb), 0);
        tick; settle;
        chk("cp_back", 32'(detect_add), 1);
        chk("cp_wr_cycles", 32'(wr_cnt), 6);
        chk("cp_lfd_once", 32'(lfd_cnt), 1);

        // busy destination, addr 2
        full = 3'b100; empty = 3'b011; pkt_valid = 1'b1; addr_in = 2'd2;
        settle;
        chk("bd_vld", 32'(vld_out), 4);
        for (int i = 0; i < 3; i++) begin
            tick; settle;
            chk("bd_wait_busy", 32'(busy), 1);
            chk("bd_wait_we", 32'(write_enb), 0);
            chk("bd_wait_lfd", 32'(lfd_state), 0);
        end
        full = 3'b000; empty = 3'b111; settle;
        chk("bd_still_wait", 32'(lfd_state), 0);
        tick; settle;
        chk("bd_lfd", 32'(lfd_state), 1);
        chk("bd_lfd_we", 32'(write_enb), 4);
        tick; pkt_valid = 1'b0; settle;
        tick; settle;
        chk("bd_lp_we", 32'(write_enb), 4);
        tick; tick; settle;
        chk("bd_back", 32'(detect_add), 1);

        // full mid-payload, addr 0
        pkt_valid = 1'b1; addr_in = 2'd0;
        tick; settle;
        chk("fm_lfd_we", 32'(write_enb), 1);
        tick; settle;
        chk("fm_ld_we", 32'(write_enb), 1);
        tick; full = 3'b001; settle;
        chk("fm_rise_we", 32'(write_enb), 0);
        chk("fm_rise_busy", 32'(busy), 0);
        tick; settle;
        chk("fm_full_busy", 32'(busy), 1);
        chk("fm_full_we", 32'(write_enb), 0);
        tick; full = 3'b000; settle;
        chk("fm_full2_busy", 32'(busy), 1);
        chk("fm_full2_we", 32'(write_enb), 0);
        tick; settle;
        chk("fm_laf", 32'(laf_state), 1);
        chk("fm_laf_we", 32'(write_enb), 1);
        tick; settle;
        chk("fm_ld_again", 32'(ld_state), 1);
        pkt_valid = 1'b0;
        tick; tick; settle;
        chk("fm_chk", 32'(chk_state), 1);
        tick; settle;
        chk("fm_back", 32'(detect_add), 1);

        // full on parity, addr 0
        pkt_valid = 1'b1; addr_in = 2'd0;
        tick; tick; pkt_valid = 1'b0;
        tick; full = 3'b001; settle;
        chk("fp_lp_we", 32'(write_enb), 0);
        chk("fp_lp_busy", 32'(busy), 1);
        tick; full = 3'b000; settle;
        chk("fp_full_we", 32'(write_enb), 0);
        chk("fp_full_busy", 32'(busy), 1);
        tick; settle;
        chk("fp_laf", 32'(laf_state), 1);
        chk("fp_laf_we", 32'(write_enb), 1);
        tick; settle;
        chk("fp_chk", 32'(chk_state), 1);
        chk("fp_no_ld", 32'(ld_state), 0);
        tick; settle;
        chk("fp_back", 32'(detect_add), 1);

        // timeout on port 1 while idle
        empty = 3'b101; read_enb = 3'b000;
        for (int n = 1; n <= 31; n++) begin
            tick;
            chk("to_pulse", 32'(soft_reset), (n == 30) ? 2 : 0);
        end
        empty = 3'b111;
        tick;

        // read at cycle 29 restarts the count
        empty = 3'b101;
        for (int n = 1; n <= 32; n++) begin
            read_enb = (n == 29) ? 3'b010 : 3'b000;
            tick;
            chk("to_read29", 32'(soft_reset), 0);
        end
        empty = 3'b111; read_enb = 3'b000;
        tick;

        // timeout aborts a packet in progress on port 1
        pkt_valid = 1'b1; addr_in = 2'd1;
        tick; empty = 3'b101; settle;
        chk("ab_lfd", 32'(lfd_state), 1);
        repeat (29) tick;
        settle;
        chk("ab_ld", 32'(ld_state), 1);
        chk("ab_pre_soft", 32'(soft_reset), 0);
        tick; settle;
        chk("ab_soft", 32'(soft_reset), 2);
        chk("ab_no_write", 32'(write_enb), 0);
        tick; settle;
        chk("ab_decode", 32'(detect_add), 1);
        chk("ab_soft_gone", 32'(soft_reset), 0);
        pkt_valid = 1'b0; empty = 3'b111;
        tick;

        // reset while in FIFO_FULL
        pkt_valid = 1'b1; addr_in = 2'd0;
        tick; tick; full = 3'b001;
        tick; settle;
        chk("rf_full_busy", 32'(busy), 1);
        resetn = 1'b0;
        tick; settle;
        chk("rf_detect", 32'(detect_add), 1);
        chk("rf_busy", 32'(busy), 0);
        chk("rf_we", 32'(write_enb), 0);
        chk("rf_soft", 32'(soft_reset), 0);
        resetn = 1'b1; full = 3'b000; pkt_valid = 1'b0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
